player_ctrl: RTL and testbench



---
 rtl/state_pkg.sv | 14 +
 rtl/vga_pkg.sv | 5 +
 rtl/btn_sync.sv | 21 ++
 rtl/player_ctrl.sv | 150 +++++++++++++++
 tb/tb_player_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/state_pkg.sv
// Player facing state (consumed by draw_player) and vertical motion state.
package state_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RIGHT = 2'd1,
        LEFT  = 2'd2
    } State;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } vstate_t;
endpackage

// File: rtl/vga_pkg.sv
// Screen geometry shared by the VGA timing chain and the sprite logic.
package vga_pkg;
    localparam int HOR_PIXELS = 1024;
    localparam int SPRITE_W   = 40;
endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for asynchronous button inputs.
module btn_sync #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/player_ctrl.sv
// Turns left/right/jump buttons into a clamped sprite position and facing state,
// updating once per frame on the rising edge of vblnk.
module player_ctrl
    import state_pkg::*;
#(
    parameter int X_START  = 0,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = vga_pkg::HOR_PIXELS - vga_pkg::SPRITE_W,
    parameter int Y_GROUND = 420,
    parameter int STEP_X   = 4,
    parameter int JUMP_V0  = 12,
    parameter int GRAVITY  = 1,
    parameter int V_MAX    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    output logic [11:0] player_xpos,
    output logic [11:0] player_ypos,
    output State        state,
    output logic        airborne
);
    localparam logic signed [12:0] STEP13 = 13'(STEP_X);
    localparam logic signed [12:0] XMIN13 = 13'(X_MIN);
    localparam logic signed [12:0] XMAX13 = 13'(X_MAX);
    localparam logic [12:0]        YG13   = 13'(Y_GROUND);
    localparam logic [7:0]         V0_8   = 8'(JUMP_V0);
    localparam logic [7:0]         GRAV8  = 8'(GRAVITY);
    localparam logic [8:0]         GRAV9  = 9'(GRAVITY);
    localparam logic [8:0]         VMAX9  = 9'(V_MAX);

    logic [2:0] btn_s;
    logic       left, right, jump;
    logic       vblnk_q, tick;

    vstate_t    vstate, vstate_nxt;
    logic [7:0] vel, vel_nxt;
    logic       jump_armed, armed_nxt;
    logic [11:0] x_nxt, y_nxt;
    State       state_nxt;

    logic signed [12:0] x_cur, x_tmp;
    logic [12:0] y_up, y_dn;
    logic [8:0]  v_sum;
    logic [7:0]  v_new;

    btn_sync #(.W(3)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({btn_left, btn_right, btn_jump}),
        .q   (btn_s)
    );

    assign left  = btn_s[2];
    assign right = btn_s[1];
    assign jump  = btn_s[0];
    assign tick  = vblnk & ~vblnk_q;

    always_comb begin
        state_nxt = IDLE;
        x_nxt     = player_xpos;
        x_cur     = {1'b0, player_xpos};
        x_tmp     = x_cur;
        // 13-bit signed math so the clamp sees the value before any wrap
        if (left & ~right) begin
            state_nxt = LEFT;
            x_tmp     = x_cur - STEP13;
            x_nxt     = (x_tmp < XMIN13) ? XMIN13[11:0] : x_tmp[11:0];
        end else if (right & ~left) begin
            state_nxt = RIGHT;
            x_tmp     = x_cur + STEP13;
            x_nxt     = (x_tmp > XMAX13) ? XMAX13[11:0] : x_tmp[11:0];
        end
    end

    always_comb begin
        vstate_nxt = vstate;
        vel_nxt    = vel;
        armed_nxt  = jump_armed;
        y_nxt      = player_ypos;
        y_up       = {1'b0, player_ypos} - {5'b0, vel};
        v_sum      = {1'b0, vel} + GRAV9;
        v_new      = (v_sum > VMAX9) ? VMAX9[7:0] : v_sum[7:0];
        y_dn       = {1'b0, player_ypos} + {5'b0, v_new};
        case (vstate)
            GROUND: begin
                if (jump & jump_armed) begin
                    vstate_nxt = RISE;
                    vel_nxt    = V0_8;
                    armed_nxt  = 1'b0;
                end else if (~jump) begin
                    armed_nxt  = 1'b1;
                end
            end
            RISE: begin
                y_nxt = y_up[11:0];
                if (vel <= GRAV8) begin
                    vstate_nxt = FALL;
                    vel_nxt    = '0;
                end else begin
                    vel_nxt    = vel - GRAV8;
                end
                // Top-of-screen guard: never let ypos underflow
                if ({4'b0, vel} > player_ypos) begin
                    y_nxt      = '0;
                    vstate_nxt = FALL;
                    vel_nxt    = '0;
                end
            end
            FALL: begin
                if (y_dn >= YG13) begin
                    y_nxt      = YG13[11:0];
                    vel_nxt    = '0;
                    vstate_nxt = GROUND;
                end else begin
                    y_nxt      = y_dn[11:0];
                    vel_nxt    = v_new;
                end
            end
            default: vstate_nxt = GROUND;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_q     <= 1'b0;
            player_xpos <= 12'(X_START);
            player_ypos <= YG13[11:0];
            state       <= IDLE;
            airborne    <= 1'b0;
            vstate      <= GROUND;
            vel         <= '0;
            jump_armed  <= 1'b1;
        end else begin
            vblnk_q <= vblnk;
            if (tick) begin
                player_xpos <= x_nxt;
                player_ypos <= y_nxt;
                state       <= state_nxt;
                airborne    <= (vstate_nxt != GROUND);
                vstate      <= vstate_nxt;
                vel         <= vel_nxt;
                jump_armed  <= armed_nxt;
            end
        end
    end
endmodule

// File: tb/tb_player_ctrl.sv
// Frame-level bench: directed test-plan sequences plus random button frames,
// checked against a trajectory-queue model of the player.
module tb_player_ctrl;
    import state_pkg::*;

    localparam int XMAX = 984;
    localparam int YG   = 420;
    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rst, vblnk, btn_left, btn_right, btn_jump;
    logic [11:0] player_xpos, player_ypos;
    State        state;
    logic        airborne;

    int n_chk = 0;
    int n_err = 0;

    // model
    int mx, my, mst;
    bit armed;
    int traj[$];
    int jump_path[$];

    player_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .vblnk       (vblnk),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_jump    (btn_jump),
        .player_xpos (player_xpos),
        .player_ypos (player_ypos),
        .state       (state),
        .airborne    (airborne)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".x"},   int'(player_xpos), mx);
        chk({tag, ".y"},   int'(player_ypos), my);
        chk({tag, ".st"},  int'(state), mst);
        chk({tag, ".air"}, int'(airborne), (traj.size() != 0) ? 1 : 0);
    endtask

    // Ballistic path from launch to landing, one entry per frame.
    task automatic build_path();
        int v, y;
        v = 12; y = YG;
        jump_path.delete();
        while (v > 0) begin
            y -= v; jump_path.push_back(y); v -= 1;
        end
        v = 0;
        do begin
            v = (v + 1 > 16) ? 16 : v + 1;
            y += v;
            if (y >= YG) y = YG;
            jump_path.push_back(y);
        end while (y != YG);
    endtask

    task automatic model_reset();
        mx = 0; my = YG; mst = int'(IDLE); armed = 1'b1; traj.delete();
    endtask

    task automatic model_tick(input bit l, input bit r, input bit j);
        if (l && !r) begin
            mst = int'(LEFT);  mx = (mx - STEP < 0) ? 0 : mx - STEP;
        end else if (r && !l) begin
            mst = int'(RIGHT); mx = (mx + STEP > XMAX) ? XMAX : mx + STEP;
        end else begin
            mst = int'(IDLE);
        end
        if (traj.size() != 0) my = traj.pop_front();
        else if (j && armed) begin
            armed = 1'b0; traj = jump_path;
        end else if (!j) armed = 1'b1;
    endtask

    task automatic frame(input bit l, input bit r, input bit j, input string tag);
        btn_left = l; btn_right = r; btn_jump = j;
        repeat (4) @(negedge clk);
        chk({tag, ".pre_y"}, int'(player_ypos), my);
        vblnk = 1'b1;
        @(negedge clk);
        model_tick(l, r, j);
        check_all(tag);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        vblnk = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        build_path();
        rst = 1'b1; vblnk = 1'b0; btn_left = 0; btn_right = 0; btn_jump = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_all("reset");
        frame(0, 0, 0, "idle0");

        // move right 3 frames then release
        for (int i = 0; i < 3; i++) frame(0, 1, 0, "right");
        chk("right3.x", int'(player_xpos), 12);
        frame(0, 0, 0, "release");

        // back to 0, then clamp at left edge
        for (int i = 0; i < 3; i++) frame(1, 0, 0, "left");
        frame(1, 0, 0, "lclamp");
        chk("lclamp.x", int'(player_xpos), 0);
        frame(1, 1, 0, "both");

        // run to right edge then clamp
        for (int i = 0; i < 246; i++) frame(0, 1, 0, "run");
        chk("redge.x", int'(player_xpos), XMAX);
        frame(0, 1, 0, "rclamp");
        chk("rclamp.x", int'(player_xpos), XMAX);

        // full jump
        frame(0, 0, 1, "launch");
        for (int i = 0; i < 12; i++) frame(0, 0, 0, "rise");
        chk("apex.y", int'(player_ypos), 342);
        for (int i = 0; i < 12; i++) frame(0, 0, 0, "fall");
        chk("land.y", int'(player_ypos), YG);
        chk("land.air", int'(airborne), 0);

        // held jump: exactly one jump in 60 frames
        for (int i = 0; i < 60; i++) frame(0, 0, 1, "held");
        frame(0, 0, 0, "rearm");
        frame(0, 0, 1, "jump2");
        chk("jump2.air", int'(airborne), 1);

        // reset mid-jump at apex
        for (int i = 0; i < 12; i++) frame(0, 0, 0, "rise2");
        chk("apex2.y", int'(player_ypos), 342);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_all("midrst");

        // level-high vblnk produces a single update
        btn_right = 1'b1;
        repeat (4) @(negedge clk);
        vblnk = 1'b1;
        repeat (1000) @(negedge clk);
        model_tick(0, 1, 0);
        check_all("level");
        vblnk = 1'b0;
        btn_right = 1'b0;
        @(negedge clk);

        // random frames
        for (int i = 0; i < 300; i++) begin
            bit l, r, j;
            l = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 1) == 0);
            j = ($urandom_range(0, 5) == 0);
            frame(l, r, j, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
